// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program-counter register and instruction-fetch sequencer
// sitting directly upstream of the PC+4 Adder.
//
// The current PC is driven out on pc_o (Adder src1_i) and the Adder's sum
// comes back on seq_pc_i as the sequential next PC. This block never adds 4
// itself. One instruction-memory request is issued per PC.
//
// Handshake: imem_req_o is high in REQ whenever stall_i is low; a transfer
// happens in any cycle where imem_req_o && imem_ack_i, and imem_ack_i is
// ignored while imem_req_o is low. Completion is reported one cycle later as
// a single-cycle inst_valid_o pulse carrying inst_pc_o.
//
// Ports:
//   clk_i          clock, all state updates on the rising edge
//   rst_i          synchronous active-high reset
//   pc_o           current fetch PC (to Adder src1_i)
//   seq_pc_i       Adder sum (pc_o + 4)
//   redirect_i     branch/jump taken this cycle
//   redirect_pc_i  redirect target (must be word aligned)
//   stall_i        downstream cannot accept an instruction
//   imem_req_o     fetch request for pc_o
//   imem_ack_i     memory accepts/returns the request
//   inst_valid_o   one-cycle pulse: fetch of inst_pc_o completed
//   inst_pc_o      PC of the completed fetch
//   fetch_cnt_o    number of completed fetches (wraps)
//   err_o          sticky error flag (misaligned redirect or fetch timeout)
//
// Optional feature: define FETCH_TIMEOUT_EN to add a request-wait counter.
// A request left unacknowledged for TIMEOUT_CYC consecutive cycles sends the
// block to ERR. Without the macro REQ waits for ack indefinitely.

module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          TIMEOUT_CYC = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic [31:0] pc_o,
   input  logic [31:0] seq_pc_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        stall_i,
   output logic        imem_req_o,
   input  logic        imem_ack_i,
   output logic        inst_valid_o,
   output logic [31:0] inst_pc_o,
   output logic [31:0] fetch_cnt_o,
   output logic        err_o
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      REQ  = 2'd1,
      ERR  = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        inst_valid_q, inst_valid_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic        err_q, err_d;
   logic        req;
   logic        xfer;

`ifdef FETCH_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
   logic [WAIT_W-1:0] wait_q, wait_d;
`endif

   assign req  = (state_q == REQ) && !stall_i;
   assign xfer = req && imem_ack_i;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      inst_valid_d = 1'b0;
      inst_pc_d    = inst_pc_q;
      fetch_cnt_d  = fetch_cnt_q;
      err_d        = err_q;
`ifdef FETCH_TIMEOUT_EN
      wait_d       = wait_q;
`endif
      unique case (state_q)
         BOOT: begin
            // Redirects are ignored here; the first request follows next cycle.
            state_d = REQ;
`ifdef FETCH_TIMEOUT_EN
            wait_d  = '0;
`endif
         end
         REQ: begin
            if (redirect_i) begin
               // Redirect outranks stall and squashes any same-cycle transfer.
               if (redirect_pc_i[1:0] == 2'b00) begin
                  pc_d = redirect_pc_i;
               end else begin
                  state_d = ERR;
                  err_d   = 1'b1;
               end
`ifdef FETCH_TIMEOUT_EN
               wait_d = '0;
`endif
            end else if (xfer) begin
               pc_d         = seq_pc_i;
               inst_valid_d = 1'b1;
               inst_pc_d    = pc_q;
               fetch_cnt_d  = fetch_cnt_q + 32'd1;
`ifdef FETCH_TIMEOUT_EN
               wait_d       = '0;
`endif
            end
`ifdef FETCH_TIMEOUT_EN
            else if (stall_i) begin
               wait_d = '0;
            end else if (wait_q == WAIT_W'(TIMEOUT_CYC - 1)) begin
               // wait_q counts earlier unacked cycles, so this is the
               // TIMEOUT_CYC-th one; an ack now would have taken the xfer branch.
               state_d = ERR;
               err_d   = 1'b1;
               wait_d  = '0;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
`endif
         end
         ERR: begin
            // Only reset leaves ERR.
         end
         default: begin
            state_d = ERR;
            err_d   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= BOOT;
         pc_q         <= RESET_PC;
         inst_valid_q <= 1'b0;
         inst_pc_q    <= 32'h0;
         fetch_cnt_q  <= 32'h0;
         err_q        <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         wait_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_valid_q <= inst_valid_d;
         inst_pc_q    <= inst_pc_d;
         fetch_cnt_q  <= fetch_cnt_d;
         err_q        <= err_d;
`ifdef FETCH_TIMEOUT_EN
         wait_q       <= wait_d;
`endif
      end
   end

   assign pc_o         = pc_q;
   assign imem_req_o   = req;
   assign inst_valid_o = inst_valid_q;
   assign inst_pc_o    = inst_pc_q;
   assign fetch_cnt_o  = fetch_cnt_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed testbench for pc_fetch_ctrl. The PC+4 Adder is modelled by a
// continuous assign. Inputs change 1 ns after each rising edge; registered
// outputs are checked there, and imem_req_o is checked 1 ns after the inputs
// that drive it have settled.

module tb_pc_fetch_ctrl;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] pc_o;
   logic [31:0] seq_pc_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        stall_i;
   logic        imem_req_o;
   logic        imem_ack_i;
   logic        inst_valid_o;
   logic [31:0] inst_pc_o;
   logic [31:0] fetch_cnt_o;
   logic        err_o;

   int pass_cnt = 0;
   int total_cnt = 0;

   pc_fetch_ctrl #(
      .RESET_PC   (RST_PC),
      .TIMEOUT_CYC(16)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .pc_o         (pc_o),
      .seq_pc_i     (seq_pc_i),
      .redirect_i   (redirect_i),
      .redirect_pc_i(redirect_pc_i),
      .stall_i      (stall_i),
      .imem_req_o   (imem_req_o),
      .imem_ack_i   (imem_ack_i),
      .inst_valid_o (inst_valid_o),
      .inst_pc_o    (inst_pc_o),
      .fetch_cnt_o  (fetch_cnt_o),
      .err_o        (err_o)
   );

   // Adder model
   assign seq_pc_i = pc_o + 32'd4;

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      if (obs === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   // Inputs have just changed; let combinational req settle, then check.
   task automatic check_req(input string tag, input logic exp);
      #1;
      check(tag, {31'b0, imem_req_o}, {31'b0, exp});
   endtask

   task automatic check_regs(input string tag, input logic [31:0] e_pc, input logic e_valid,
                             input logic [31:0] e_ipc, input logic [31:0] e_cnt, input logic e_err);
      check({tag, ".pc"},    pc_o, e_pc);
      check({tag, ".valid"}, {31'b0, inst_valid_o}, {31'b0, e_valid});
      check({tag, ".ipc"},   inst_pc_o, e_ipc);
      check({tag, ".cnt"},   fetch_cnt_o, e_cnt);
      check({tag, ".err"},   {31'b0, err_o}, {31'b0, e_err});
   endtask

   initial begin
      rst_i = 1'b1; imem_ack_i = 1'b1; stall_i = 1'b0;
      redirect_i = 1'b0; redirect_pc_i = 32'h0;

      // Reset state
      step(2);
      check_regs("rst", RST_PC, 1'b0, 32'h0, 32'h0, 1'b0);
      check_req("rst.req", 1'b0);

      // BOOT -> REQ, first request one cycle after reset falls
      rst_i = 1'b0;
      step(1);
      check_req("boot.req", 1'b1);
      check_regs("boot", RST_PC, 1'b0, 32'h0, 32'h0, 1'b0);

      // Sequential fetch with ack held high
      step(1);
      check_regs("seq1", 32'h104, 1'b1, 32'h100, 32'd1, 1'b0);
      step(1);
      check_regs("seq2", 32'h108, 1'b1, 32'h104, 32'd2, 1'b0);

      // Stall three cycles at 0x108
      stall_i = 1'b1;
      check_req("stall.req", 1'b0);
      step(3);
      check_regs("stall", 32'h108, 1'b0, 32'h104, 32'd2, 1'b0);
      stall_i = 1'b0;
      check_req("resume.req", 1'b1);
      step(1);
      check_regs("resume", 32'h10C, 1'b1, 32'h108, 32'd3, 1'b0);

      // Redirect together with ack and stall
      redirect_i = 1'b1; redirect_pc_i = 32'h0000_2000; stall_i = 1'b1;
      step(1);
      check_regs("redir_stall", 32'h2000, 1'b0, 32'h108, 32'd3, 1'b0);

      // Redirect squashing a real transfer
      redirect_pc_i = 32'h0000_3000; stall_i = 1'b0;
      check_req("redir_xfer.req", 1'b1);
      step(1);
      check_regs("redir_xfer", 32'h3000, 1'b0, 32'h108, 32'd3, 1'b0);

      // PC wrap
      redirect_pc_i = 32'hFFFF_FFFC;
      step(1);
      check("wrap.setup.pc", pc_o, 32'hFFFF_FFFC);
      redirect_i = 1'b0;
      step(1);
      check_regs("wrap", 32'h0, 1'b1, 32'hFFFF_FFFC, 32'd4, 1'b0);

      // Reset while a request waits for ack; ack in reset cycle ignored
      imem_ack_i = 1'b0;
      step(1);
      check_regs("wait", 32'h0, 1'b0, 32'hFFFF_FFFC, 32'd4, 1'b0);
      rst_i = 1'b1; imem_ack_i = 1'b1;
      step(1);
      check_regs("midrst", RST_PC, 1'b0, 32'h0, 32'h0, 1'b0);
      check_req("midrst.req", 1'b0);
      rst_i = 1'b0;
      step(2);
      check_regs("refetch", 32'h104, 1'b1, 32'h100, 32'd1, 1'b0);

      // Misaligned redirect -> ERR, sticky, req stays low
      redirect_i = 1'b1; redirect_pc_i = 32'h0000_2002;
      step(1);
      check_regs("misalign", 32'h104, 1'b0, 32'h100, 32'd1, 1'b1);
      redirect_pc_i = 32'h0000_4000;
      check_req("err.req", 1'b0);
      step(1);
      redirect_i = 1'b0;
      step(2);
      check_regs("err_hold", 32'h104, 1'b0, 32'h100, 32'd1, 1'b1);
      check_req("err_hold.req", 1'b0);

      // Reset pulse recovers; redirect during BOOT is ignored
      rst_i = 1'b1;
      step(1);
      rst_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h0000_4000;
      step(1);
      check_regs("boot_redir", RST_PC, 1'b0, 32'h0, 32'h0, 1'b0);
      redirect_i = 1'b0;

`ifdef FETCH_TIMEOUT_EN
      // Ack on the 16th waiting cycle: normal transfer
      imem_ack_i = 1'b0;
      step(15);
      check("to15.err", {31'b0, err_o}, 32'h0);
      imem_ack_i = 1'b1;
      step(1);
      check_regs("to_ack16", 32'h104, 1'b1, 32'h100, 32'd1, 1'b0);
      // Withhold ack 16 cycles: timeout error
      imem_ack_i = 1'b0;
      step(15);
      check("to_b15.err", {31'b0, err_o}, 32'h0);
      step(1);
      check_regs("timeout", 32'h104, 1'b0, 32'h100, 32'd1, 1'b1);
      check_req("timeout.req", 1'b0);
`else
      // Without the timeout, a long wait never errors
      imem_ack_i = 1'b0;
      step(40);
      check_regs("nowait_err", RST_PC, 1'b0, 32'h0, 32'h0, 1'b0);
      check_req("nowait.req", 1'b1);
      imem_ack_i = 1'b1;
      step(1);
      check_regs("late_ack", 32'h104, 1'b1, 32'h100, 32'd1, 1'b0);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
